// File: rtl/pe_result_drain_pkg.sv
// Shared sizing for the PE result drain path: beat and result widths
// derived from the PE array geometry.
package pe_result_drain_pkg;
  localparam int ARRAY_NUM  = 3;
  localparam int BLOCK_NUM  = 3;
  localparam int BEAT_W     = 8 * ARRAY_NUM;
  localparam int RES_W      = BEAT_W * BLOCK_NUM;
  localparam int BEAT_CNT_W = $clog2(BLOCK_NUM);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BLOCK_NUM - 1);
endpackage

// File: rtl/pe_result_drain_if.sv
// Beat stream from the result drain toward the output buffer / DMA.
interface pe_result_drain_if;
  import pe_result_drain_pkg::*;

  logic [BEAT_W-1:0] oData;
  logic              oValid;
  logic              iReady;
  logic              oLast;

  modport master (output oData, output oValid, output oLast, input iReady);
  modport slave  (input oData, input oValid, input oLast, output iReady);
endinterface

// File: rtl/pe_result_drain_slot_mux.sv
// Selects one beat (one PE array's worth of bytes) out of a full block
// result; array 0 occupies the least-significant beat.
module pe_result_slot_mux
  import pe_result_drain_pkg::*;
(
  input  logic [RES_W-1:0]      iSlot,
  input  logic [BEAT_CNT_W-1:0] iBeat,
  input  logic                  iEn,
  output logic [BEAT_W-1:0]     oBeat
);

  always_comb begin
    oBeat = '0;
    if (iEn) begin
      for (int b = 0; b < BLOCK_NUM; b++) begin
        if (iBeat == BEAT_CNT_W'(b)) oBeat = iSlot[b*BEAT_W +: BEAT_W];
      end
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Two-slot ping-pong buffer that captures PE block results and drains each
// one as BLOCK_NUM beats over a valid/ready stream.
module pe_result_drain
  import pe_result_drain_pkg::*;
(
  input  logic                   iClk,
  input  logic                   iRstN,
  input  logic [RES_W-1:0]       iResult,
  input  logic                   iResultValid,
  input  logic                   iFlush,
  input  logic                   iClearErr,
  output logic                   oOverflow,
  output logic [1:0]             oCount,
  pe_result_drain_if.master      stream
);

  logic [RES_W-1:0]      r_slot [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic [BEAT_CNT_W-1:0] r_beat;
  logic                  r_ovf;

  logic                  w_valid;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_space;
  logic                  w_cap;
  logic                  w_drop;
  logic [BEAT_W-1:0]     w_beat_data;

  assign w_valid = (r_count != 2'd0);
  assign w_xfer  = w_valid & stream.iReady;
  assign w_pop   = w_xfer & (r_beat == LAST_BEAT);
  // A full buffer still has room if the oldest result leaves this cycle.
  assign w_space = (r_count != 2'd2) | w_pop;
  assign w_cap   = iResultValid & w_space;
  assign w_drop  = iResultValid & ~w_space;

  pe_result_slot_mux u_slot_mux (
    .iSlot (r_slot[r_rd_ptr]),
    .iBeat (r_beat),
    .iEn   (w_valid),
    .oBeat (w_beat_data)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_beat    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (iClearErr) r_ovf <= 1'b0;

      if (iFlush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
        r_beat   <= '0;
      end else begin
        if (w_cap) begin
          r_slot[r_wr_ptr] <= iResult;
          r_wr_ptr         <= ~r_wr_ptr;
        end
        if (w_xfer) begin
          if (w_pop) begin
            r_beat   <= '0;
            r_rd_ptr <= ~r_rd_ptr;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        case ({w_cap, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign stream.oValid = w_valid;
  assign stream.oData  = w_beat_data;
  assign stream.oLast  = w_valid & (r_beat == LAST_BEAT);
  assign oOverflow     = r_ovf;
  assign oCount        = r_count;

endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the buffer.
module tb_pe_result_drain;
  import pe_result_drain_pkg::*;

  logic             iClk = 1'b0;
  logic             iRstN;
  logic [RES_W-1:0] iResult;
  logic             iResultValid;
  logic             iFlush;
  logic             iClearErr;
  logic             oOverflow;
  logic [1:0]       oCount;

  pe_result_drain_if sif ();

  pe_result_drain dut (
    .iClk         (iClk),
    .iRstN        (iRstN),
    .iResult      (iResult),
    .iResultValid (iResultValid),
    .iFlush       (iFlush),
    .iClearErr    (iClearErr),
    .oOverflow    (oOverflow),
    .oCount       (oCount),
    .stream       (sif.master)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RES_W-1:0] q[$];
  int               m_beat = 0;
  bit               m_ovf  = 1'b0;

  localparam logic [RES_W-1:0] RA = 72'h090807_060504_030201;
  localparam logic [RES_W-1:0] RB = 72'h1C1B1A_161514_131211;
  localparam logic [RES_W-1:0] RC = 72'h2C2B2A_262524_232221;
  localparam logic [RES_W-1:0] RD = 72'hF3F2F1_E3E2E1_D3D2D1;

  task automatic chk(input string nm, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BEAT_W-1:0] m_data();
    logic [RES_W-1:0] head;
    if (q.size() == 0) return '0;
    head = q[0];
    return head[m_beat*BEAT_W +: BEAT_W];
  endfunction

  task automatic model_reset();
    q.delete();
    m_beat = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    bit valid, xfer, lastx, space, drop;
    valid = (q.size() != 0);
    xfer  = valid && sif.iReady;
    lastx = xfer && (m_beat == BLOCK_NUM - 1);
    space = (q.size() < 2) || lastx;
    drop  = iResultValid && !space;
    if (drop)           m_ovf = 1'b1;
    else if (iClearErr) m_ovf = 1'b0;
    if (iFlush) begin
      q.delete();
      m_beat = 0;
    end else begin
      if (xfer) begin
        if (lastx) begin
          void'(q.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (iResultValid && space) q.push_back(iResult);
    end
  endtask

  task automatic check_all();
    bit valid;
    valid = (q.size() != 0);
    chk("oValid",    RES_W'(sif.oValid), RES_W'(valid));
    chk("oData",     RES_W'(sif.oData),  RES_W'(m_data()));
    chk("oLast",     RES_W'(sif.oLast),  RES_W'(valid && (m_beat == BLOCK_NUM - 1)));
    chk("oOverflow", RES_W'(oOverflow),  RES_W'(m_ovf));
    chk("oCount",    RES_W'(oCount),     RES_W'(q.size()));
  endtask

  task automatic drive(input bit rv, input logic [RES_W-1:0] res, input bit rdy,
                       input bit fl, input bit clr);
    iResultValid = rv;
    iResult      = res;
    sif.iReady   = rdy;
    iFlush       = fl;
    iClearErr    = clr;
  endtask

  task automatic cycle();
    @(posedge iClk);
    if (iRstN) model_step();
    @(negedge iClk);
    check_all();
  endtask

  initial begin
    iRstN = 1'b0;
    drive(1'b1, RA, 1'b1, 1'b0, 1'b0);
    model_reset();

    // Reset held with a capture strobe asserted: nothing may be taken.
    repeat (3) begin
      cycle();
      chk("rst_valid", RES_W'(sif.oValid), '0);
      chk("rst_data",  RES_W'(sif.oData),  '0);
      chk("rst_count", RES_W'(oCount),     '0);
    end
    iRstN = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Single capture, ready high.
    drive(1'b1, RA, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("t2_b0", RES_W'(sif.oData), 72'h030201);
    chk("t2_l0", RES_W'(sif.oLast), 72'h0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("t2_b1", RES_W'(sif.oData), 72'h060504);
    cycle();
    chk("t2_b2", RES_W'(sif.oData), 72'h090807);
    chk("t2_l2", RES_W'(sif.oLast), 72'h1);
    cycle();
    chk("t2_empty", RES_W'({sif.oValid, oCount}), 72'h0);

    // Back-pressure holds the first beat.
    drive(1'b1, RA, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t3_hold", RES_W'(sif.oData), 72'h030201);
    repeat (4) begin
      cycle();
      chk("t3_hold", RES_W'(sif.oData), 72'h030201);
      chk("t3_nolast", RES_W'(sif.oLast), 72'h0);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();
    chk("t3_done", RES_W'(oCount), 72'h0);

    // Overflow on a third capture, then drain and clear.
    drive(1'b1, RA, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, RB, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, RC, 1'b0, 1'b0, 1'b0); cycle();
    chk("t4_count", RES_W'(oCount), 72'h2);
    chk("t4_ovf",   RES_W'(oOverflow), 72'h1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("t4_a1", RES_W'(sif.oData), 72'h060504);
    repeat (2) cycle();
    chk("t4_b0", RES_W'(sif.oData), 72'h131211);
    repeat (3) cycle();
    chk("t4_drained", RES_W'(oCount), 72'h0);
    chk("t4_sticky",  RES_W'(oOverflow), 72'h1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1); cycle();
    chk("t4_cleared", RES_W'(oOverflow), 72'h0);

    // Final beat pop coincides with a capture while full.
    drive(1'b1, RA, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, RB, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();
    chk("t5_last", RES_W'(sif.oLast), 72'h1);
    drive(1'b1, RC, 1'b1, 1'b0, 1'b0); cycle();
    chk("t5_count", RES_W'(oCount), 72'h2);
    chk("t5_noovf", RES_W'(oOverflow), 72'h0);
    chk("t5_b0",    RES_W'(sif.oData), 72'h131211);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();
    chk("t5_c0", RES_W'(sif.oData), 72'h232221);
    repeat (3) cycle();
    chk("t5_done", RES_W'(oCount), 72'h0);

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, RA, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, RB, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t6_mid", RES_W'(sif.oData), 72'h060504);
    iRstN = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", RES_W'(sif.oValid), 72'h0);
    chk("t6_last",  RES_W'(sif.oLast),  72'h0);
    chk("t6_data",  RES_W'(sif.oData),  72'h0);
    chk("t6_count", RES_W'(oCount),     72'h0);
    @(negedge iClk);
    iRstN = 1'b1;
    drive(1'b1, RD, 1'b1, 1'b0, 1'b0); cycle();
    chk("t6_fresh", RES_W'(sif.oData), 72'hD3D2D1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 4),
            {$urandom(), $urandom(), $urandom()},
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 5));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Downstream neighbour of the PE block.
- Captures the full-width PE block result (8*ARRAY_NUM*BLOCK_NUM bits) on a capture strobe into a 2-entry ping-pong buffer.
- Serialises each captured result as BLOCK_NUM beats of 8*ARRAY_NUM bits, one beat per PE array, over a valid/ready stream toward the output buffer/DMA.
- Lets the PE block start its next accumulation while the previous result drains.

Parameters:
ARRAY_NUM, 3, PEs per array; beat width = 8*ARRAY_NUM bits
BLOCK_NUM, 3, arrays per block; beats per result = BLOCK_NUM (>=2)

Ports:
iClk  in  1  clock, all state on rising edge
iRstN  in  1  asynchronous, active-low reset
iResult  in  8*ARRAY_NUM*BLOCK_NUM  PE block result vector
iResultValid  in  1  single-cycle capture strobe for iResult
iFlush  in  1  synchronous flush of buffered results
iClearErr  in  1  synchronous clear of oOverflow
oData  out  8*ARRAY_NUM  current beat
oValid  out  1  beat valid
iReady  in  1  downstream accepts beat
oLast  out  1  final beat of a result
oOverflow  out  1  sticky: a capture was dropped
oCount  out  2  results held (0..2)

Behaviour:
- Reset (iRstN low, async): slots cleared to 0, wr_ptr=0, rd_ptr=0, count=0, beat=0, oOverflow=0. Outputs while in reset: oValid=0, oLast=0, oData=0, oCount=0. Release is synchronous to iClk.
- Storage: two slot registers of full result width, 1-bit wr_ptr and rd_ptr, 2-bit count, beat counter 0..BLOCK_NUM-1.
- Capture: iResultValid=1 and space available writes iResult into slot[wr_ptr], toggles wr_ptr and increments count.
  - Space is available when count<2, or when count==2 and the final beat handshakes in the same cycle.
- Latency: capture edge to oValid=1 is 1 cycle.
- Output:
  - oValid = (count!=0).
  - oData = slot[rd_ptr] bits [8*ARRAY_NUM*(beat+1)-1 : 8*ARRAY_NUM*beat], i.e. array 0 first. oData=0 when count==0.
  - oLast = oValid & (beat==BLOCK_NUM-1).
- Handshake:
  - A beat transfers when oValid & iReady.
  - While oValid=1 and iReady=0, oData, oLast and beat hold stable.
  - oValid never drops without a transfer, except on flush or reset.
- On transfer:
  - If beat<BLOCK_NUM-1: beat++.
  - Otherwise: beat=0, rd_ptr toggles, count decrements.
- Simultaneous final-beat pop and capture: count unchanged. Applies at count 1 or 2.
- Overflow: iResultValid with no space available drops the capture (storage untouched) and sets oOverflow=1.
  - oOverflow stays set until iClearErr or reset.
  - iClearErr and a new drop in the same cycle: oOverflow=1 (set wins).
- Flush: iFlush=1 forces count=0, beat=0, wr_ptr=rd_ptr=0 next cycle.
  - Any transfer or capture in that cycle is discarded.
  - Slot contents and oOverflow are not cleared.
- oCount mirrors count.
- No arithmetic on data: beats are bit slices only, no sign handling.

Decomposition:
- Shared package holds:
  - localparam BEAT_W = 8*ARRAY_NUM
  - localparam RES_W = BEAT_W*BLOCK_NUM
  - localparam BEAT_CNT_W = $clog2(BLOCK_NUM)
- Sub-module pe_result_slot_mux: combinational beat-select from one slot given the beat index. It is reused by the input-side feeder.
- Pointer, count and overflow logic stay in the top.

Test Plan (ARRAY_NUM=3, BLOCK_NUM=3: 72-bit result, 24-bit beats):
1. Reset low for 3 cycles with iResultValid=1 → oValid=0, oData=0, oLast=0, oOverflow=0, oCount=0 throughout; no capture.
2. Single capture of 72'h090807_060504_030201, iReady=1 → from the next cycle, beats 24'h030201, 24'h060504, 24'h090807 on consecutive cycles; oLast only on the third; then oValid=0, oCount=0.
3. Same capture with iReady=0 for 5 cycles, then 1 → oData holds 24'h030201 and oLast=0 for 5 cycles; then the 3 beats complete in order.
4. Three captures A, B, C on consecutive cycles, iReady=0 → oCount=2, C dropped, oOverflow=1. Raise iReady → A's 3 beats then B's 3 beats. oOverflow stays 1 until a one-cycle iClearErr, then reads 0.
5. count=2, iReady=1, final beat of A coincides with capture of C → no overflow, oCount stays 2; B then C drain intact.
6. Async reset asserted mid-drain (beat=1, count=2) → oValid, oLast, oData, oCount go 0 without a clock edge. After release, a fresh capture drains starting at beat 0.
